main_mem_responder: RTL and testbench

- Memory-side responder for the data cache's refill and write-through traffic; replaces the zero-latency direct data memory with a multi-cycle word-organised memory.
- Accepts one request at a time over a valid/ready handshake, waits a programmable latency, then returns a one-cycle response pulse.
- Reads always return the full aligned word (cache line = one word); writes honour the RV32I byte/half/word access mode.

---
 rtl/main_mem_responder.sv | 153 +++++++++++++++
 tb/tb_main_mem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_responder.sv
// main_mem_responder: word-organised data memory behind a valid/ready request
// port. Each accepted request waits LATENCY cycles, performs the access and
// returns a one-cycle response pulse carrying the aligned (post-write) word.
// Optional feature macro: MEM_ERR_EN (out-of-range / misaligned detection).
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | latency countdown, access happens when the counter is 0
// RESP  | one-cycle response pulse
module main_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_addr_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt;
  logic                    accept;
  logic                    do_access;
  logic                    access_err;
  logic                    write_q;
  logic [2:0]              mode_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [IDX_W-1:0]        idx;
  logic [DATA_WIDTH-1:0]   old_word;
  logic [DATA_WIDTH-1:0]   merged;

  assign idx      = addr_q[2+IDX_W-1:2];
  assign old_word = mem[idx];
  assign accept   = req_valid && req_ready;

  // Next-state and handshake outputs derived from the current state.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    do_access  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          do_access = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and latency down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= 4'(LATENCY - 1);
      else if (state == WAIT && cnt != 4'd0)
        cnt <= cnt - 4'd1;
    end
  end

  // Capture the request fields at acceptance so the requester may move on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
      mode_q  <= 3'b010;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      write_q <= req_write;
      mode_q  <= req_addr_mode;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Byte/half/word merge of the write data into the addressed word.
  always_comb begin
    merged = old_word;
    case (mode_q)
      3'b000, 3'b100: merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      3'b001, 3'b101: merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      default:        merged = wdata_q;
    endcase
  end

`ifdef MEM_ERR_EN
  // Out-of-range upper address bits or a misaligned H/W access is an error.
  always_comb begin
    access_err = ((addr_q >> (2 + IDX_W)) != '0);
    case (mode_q)
      3'b000, 3'b100: ;
      3'b001, 3'b101: if (addr_q[0]) access_err = 1'b1;
      default:        if (addr_q[1:0] != 2'b00) access_err = 1'b1;
    endcase
  end

  // Error flag is registered alongside the response data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            resp_err <= 1'b0;
    else if (do_access) resp_err <= access_err;
  end
`else
  // Upper address bits alias onto the same words when checking is off.
  logic unused_upper;
  assign unused_upper = ^(addr_q >> (2 + IDX_W));
  assign access_err   = 1'b0;
  assign resp_err     = 1'b0;
`endif

  // Memory array has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (do_access && write_q && !access_err)
      mem[idx] <= merged;
  end

  // Response word: aligned read word, or the merged word after a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      resp_rdata <= '0;
    else if (do_access)
      resp_rdata <= access_err ? '0 : (write_q ? merged : old_word);
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed self-checking bench for main_mem_responder (LATENCY=4, DEPTH=1024).
// Build with +define+MEM_ERR_EN to exercise the error-checking variant.
module tb_main_mem_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_addr_mode = 3'b010;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  main_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr_mode(req_addr_mode),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // Issue one request; lat = index of the cycle after the accepting edge in
  // which resp_valid was seen (-1 on timeout); rdy1 = req_ready in cycle 1.
  task automatic do_req(input logic w, input logic [2:0] m, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic rdy1,
                        output logic [31:0] rd, output logic er);
    int n;
    lat = -1; rdy1 = 1'b1; rd = '0; er = 1'b0;
    @(negedge clk);
    req_write = w; req_addr_mode = m; req_addr = a; req_wdata = d; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        rdy1 = req_ready;
        req_valid = 1'b0;
      end
      if (resp_valid) begin
        lat = i; rd = resp_rdata; er = resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", resp_valid); end
    n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", resp_rdata); end
    n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", resp_err); end
    rst = 1'b0;
  endtask

  task automatic test_read_latency();
    int lat; logic r1; logic [31:0] rd; logic er;
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, r1, rd, er);
    n_checks++; if (lat != LAT + 1) begin n_fail++; $display("FAIL read_latency got %0d exp %0d", lat, LAT + 1); end
    n_checks++; if (r1 !== 1'b0) begin n_fail++; $display("FAIL ready_drop got %b exp 0", r1); end
    do_req(1'b1, 3'b010, 32'h10, 32'h12345678, lat, r1, rd, er);
    n_checks++; if (lat != LAT + 1) begin n_fail++; $display("FAIL write_latency got %0d exp %0d", lat, LAT + 1); end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, r1, rd, er);
    n_checks++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL read_10 got %h exp 12345678", rd); end
  endtask

  task automatic test_word_byte();
    int lat; logic r1; logic [31:0] rd; logic er;
    do_req(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, lat, r1, rd, er);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL w_20 got %h exp deadbeef", rd); end
    do_req(1'b1, 3'b000, 32'h22, 32'h00000055, lat, r1, rd, er);
    n_checks++; if (rd !== 32'hDE55BEEF) begin n_fail++; $display("FAIL b_22 got %h exp de55beef", rd); end
    do_req(1'b0, 3'b010, 32'h20, 32'h0, lat, r1, rd, er);
    n_checks++; if (rd !== 32'hDE55BEEF) begin n_fail++; $display("FAIL rd_20 got %h exp de55beef", rd); end
    do_req(1'b1, 3'b100, 32'h27, 32'hFFFF11A7, lat, r1, rd, er);
    do_req(1'b1, 3'b000, 32'h24, 32'h000000C3, lat, r1, rd, er);
    do_req(1'b0, 3'b010, 32'h24, 32'h0, lat, r1, rd, er);
    n_checks++; if (rd[31:24] !== 8'hA7 || rd[7:0] !== 8'hC3) begin n_fail++; $display("FAIL bu_b_24 got %h exp a7xxxxc3", rd); end
  endtask

  task automatic test_half();
    int lat; logic r1; logic [31:0] rd; logic er;
    do_req(1'b1, 3'b010, 32'h40, 32'h11223344, lat, r1, rd, er);
    do_req(1'b1, 3'b101, 32'h42, 32'h0000ABCD, lat, r1, rd, er);
    n_checks++; if (rd !== 32'hABCD3344) begin n_fail++; $display("FAIL hu_42 got %h exp abcd3344", rd); end
`ifndef MEM_ERR_EN
    do_req(1'b1, 3'b001, 32'h41, 32'h00009999, lat, r1, rd, er);
    n_checks++; if (rd !== 32'hABCD9999) begin n_fail++; $display("FAIL h_41 got %h exp abcd9999", rd); end
    do_req(1'b1, 3'b010, 32'h4B, 32'h5A5A0F0F, lat, r1, rd, er);
    do_req(1'b0, 3'b010, 32'h48, 32'h0, lat, r1, rd, er);
    n_checks++; if (rd !== 32'h5A5A0F0F) begin n_fail++; $display("FAIL w_trunc_48 got %h exp 5a5a0f0f", rd); end
    do_req(1'b1, 3'b111, 32'h1050, 32'hA5A55A5A, lat, r1, rd, er);
    do_req(1'b0, 3'b011, 32'h50, 32'h0, lat, r1, rd, er);
    n_checks++; if (rd !== 32'hA5A55A5A) begin n_fail++; $display("FAIL alias_50 got %h exp a5a55a5a", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL alias_err got %b exp 0", er); end
`else
    do_req(1'b1, 3'b001, 32'h40, 32'h00009999, lat, r1, rd, er);
    n_checks++; if (rd !== 32'hABCD9999) begin n_fail++; $display("FAIL h_40 got %h exp abcd9999", rd); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] exp_d [3];
    logic [31:0] got [3];
    int acc [3];
    int k, nresp, cyc, extra;
    addrs[0] = 32'h20; addrs[1] = 32'h40; addrs[2] = 32'h10;
    exp_d[0] = 32'hDE55BEEF; exp_d[1] = 32'hABCD9999; exp_d[2] = 32'h12345678;
    k = 0; nresp = 0; cyc = 0; extra = 0;
    for (int i = 0; i < 3; i++) begin acc[i] = 0; got[i] = '0; end
    @(negedge clk);
    req_write = 1'b0; req_addr_mode = 3'b010; req_addr = addrs[0]; req_valid = 1'b1;
    while (nresp < 3 && cyc < 80) begin
      if (resp_valid) begin
        if (nresp < 3) got[nresp] = resp_rdata;
        nresp++;
      end
      if (k < 3) begin
        req_addr = addrs[k];
        if (req_ready) begin acc[k] = cyc; k++; end
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (resp_valid) extra++;
      @(negedge clk);
    end
    n_checks++; if (nresp != 3) begin n_fail++; $display("FAIL b2b_count got %0d exp 3", nresp); end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL b2b_extra got %0d exp 0", extra); end
    // LATENCY+1 busy cycles (WAIT, RESP) separate consecutive accepting cycles
    n_checks++; if (acc[1] - acc[0] != LAT + 2) begin n_fail++; $display("FAIL b2b_gap01 got %0d exp %0d", acc[1] - acc[0], LAT + 2); end
    n_checks++; if (acc[2] - acc[1] != LAT + 2) begin n_fail++; $display("FAIL b2b_gap12 got %0d exp %0d", acc[2] - acc[1], LAT + 2); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (got[i] !== exp_d[i]) begin n_fail++; $display("FAIL b2b_data%0d got %h exp %h", i, got[i], exp_d[i]); end
    end
  endtask

  task automatic test_reset_midflight();
    int lat; logic r1; logic [31:0] rd; logic er;
    int seen;
    do_req(1'b1, 3'b010, 32'h30, 32'h0BADCAFE, lat, r1, rd, er);
    @(negedge clk);
    req_write = 1'b1; req_addr_mode = 3'b010; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b exp 1", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midrst_noresp got %0d exp 0", seen); end
    do_req(1'b0, 3'b010, 32'h30, 32'h0, lat, r1, rd, er);
    n_checks++; if (rd !== 32'h0BADCAFE) begin n_fail++; $display("FAIL midrst_mem got %h exp 0badcafe", rd); end
  endtask

`ifdef MEM_ERR_EN
  task automatic test_mem_err();
    int lat; logic r1; logic [31:0] rd; logic er;
    do_req(1'b1, 3'b010, 32'h0, 32'h01020304, lat, r1, rd, er);
    do_req(1'b1, 3'b010, 32'h1000, 32'hFFFFFFFF, lat, r1, rd, er);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_err got %b exp 1", er); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL oor_rdata got %h exp 0", rd); end
    n_checks++; if (lat != LAT + 1) begin n_fail++; $display("FAIL oor_latency got %0d exp %0d", lat, LAT + 1); end
    do_req(1'b0, 3'b010, 32'h0, 32'h0, lat, r1, rd, er);
    n_checks++; if (rd !== 32'h01020304 || er !== 1'b0) begin n_fail++; $display("FAIL word0_kept got %h/%b exp 01020304/0", rd, er); end
    do_req(1'b0, 3'b010, 32'h2, 32'h0, lat, r1, rd, er);
    n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL w_misalign got %b/%h exp 1/0", er, rd); end
    do_req(1'b1, 3'b001, 32'h1, 32'h0000BBBB, lat, r1, rd, er);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL h_misalign got %b exp 1", er); end
    do_req(1'b1, 3'b000, 32'h3, 32'h000000EE, lat, r1, rd, er);
    n_checks++; if (er !== 1'b0 || rd !== 32'hEE020304) begin n_fail++; $display("FAIL b_ok got %b/%h exp 0/ee020304", er, rd); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_latency();
    test_word_byte();
    test_half();
    test_back_to_back();
    test_reset_midflight();
`ifdef MEM_ERR_EN
    test_mem_err();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
